// File: rtl/prog_freq_divider_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prog_freq_divider_if : control/status bundle for prog_freq_divider        |
// | Optional FREQDIV_SYNC_EN adds the phase-restart strobe.  Rev 1.0          |
// +--------------------------------------------------------------------------+
interface prog_freq_divider_if #(
   parameter int unsigned BITS = 8
);
   logic            enable;
   logic            load;
   logic [BITS-1:0] divisor;
`ifdef FREQDIV_SYNC_EN
   logic            sync;
`endif
   logic            pulse;
   logic            square;
   logic            pending;
   logic [BITS-1:0] count;

`ifdef FREQDIV_SYNC_EN
   modport master (output enable, load, divisor, sync,
                   input  pulse, square, pending, count);
   modport slave  (input  enable, load, divisor, sync,
                   output pulse, square, pending, count);
`else
   modport master (output enable, load, divisor,
                   input  pulse, square, pending, count);
   modport slave  (input  enable, load, divisor,
                   output pulse, square, pending, count);
`endif
endinterface
`default_nettype wire

// File: rtl/prog_freq_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prog_freq_divider : runtime-programmable divider, tick + square output;   |
// | divisor changes only at period boundary. Macro: FREQDIV_SYNC_EN. Rev 1.0  |
// +--------------------------------------------------------------------------+
module prog_freq_divider #(
   parameter int unsigned BITS        = 8,
   parameter int unsigned DEFAULT_DIV = 10
) (
   input  wire logic              clk_i,
   input  wire logic              rst_ni,
   prog_freq_divider_if.slave     div_if
);

   localparam logic [BITS-1:0] C_ONE     = {{(BITS-1){1'b0}}, 1'b1};
   localparam logic [BITS-1:0] C_TWO     = BITS'(2);
   localparam logic [BITS-1:0] C_DEF_DIV = BITS'(DEFAULT_DIV);

   logic [BITS-1:0] count_q,   count_d;
   logic [BITS-1:0] dact_q,    dact_d;
   logic [BITS-1:0] shadow_q,  shadow_d;
   logic            pending_q, pending_d;
   logic            pulse_q,   pulse_d;
   logic            square_q,  square_d;

   logic [BITS-1:0] w_load_val;
   logic            w_wrap;
   logic            w_apply;
   logic            w_step;

   function automatic logic [BITS-1:0] half_up(input logic [BITS-1:0] d);
      return (d >> 1) + {{(BITS-1){1'b0}}, d[0]};
   endfunction

   assign w_load_val = (div_if.divisor < C_TWO) ? C_TWO : div_if.divisor;
   assign w_wrap     = (count_q == (dact_q - C_ONE));

   always_comb begin
      count_d   = count_q;
      dact_d    = dact_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      pulse_d   = 1'b0;
      square_d  = square_q;
      w_apply   = 1'b0;
      w_step    = 1'b0;

`ifdef FREQDIV_SYNC_EN
      if (div_if.sync) begin
         count_d = '0;
         pulse_d = 1'b1;
         w_apply = pending_q;
         w_step  = 1'b1;
      end else
`endif
      if (div_if.enable) begin
         w_step = 1'b1;
         if (w_wrap) begin
            count_d = '0;
            pulse_d = 1'b1;
            w_apply = pending_q;
         end else begin
            count_d = count_q + C_ONE;
         end
      end else if (pending_q) begin
         // Frozen with a value waiting: take it now and restart the period.
         count_d = '0;
         w_apply = 1'b1;
         w_step  = 1'b1;
      end

      // Apply uses the shadow as it stood before this edge.
      if (w_apply) begin
         dact_d    = shadow_q;
         pending_d = 1'b0;
      end

      if (w_step) begin
         square_d = (count_d < half_up(dact_d));
      end

      if (div_if.load) begin
         shadow_d  = w_load_val;
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q   <= '0;
         dact_q    <= C_DEF_DIV;
         shadow_q  <= C_DEF_DIV;
         pending_q <= 1'b0;
         pulse_q   <= 1'b0;
         square_q  <= 1'b0;
      end else begin
         count_q   <= count_d;
         dact_q    <= dact_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         pulse_q   <= pulse_d;
         square_q  <= square_d;
      end
   end

   assign div_if.pulse   = pulse_q;
   assign div_if.square  = square_q;
   assign div_if.pending = pending_q;
   assign div_if.count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_freq_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_prog_freq_divider : directed bench for prog_freq_divider. Rev 1.0      |
// +--------------------------------------------------------------------------+
module tb_prog_freq_divider;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   prog_freq_divider_if #(.BITS(8)) dif ();

   prog_freq_divider #(.BITS(8), .DEFAULT_DIV(10)) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .div_if (dif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Starting just after a wrap (count 0), run one full period of d edges.
   task automatic measure(input string tag, input int d);
      int pulses;
      int highs;
      pulses = 0;
      highs  = 0;
      for (int i = 0; i < d; i++) begin
         step();
         if (dif.pulse)  pulses++;
         if (dif.square) highs++;
      end
      check_eq({tag, "_pulses"},   pulses,    1);
      check_eq({tag, "_sq_high"},  highs,     (d + 1) / 2);
      check_eq({tag, "_end_pulse"}, dif.pulse, 1);
      check_eq({tag, "_end_cnt"},  dif.count, 0);
   endtask

   initial begin
      int frz_pulses;
      rst_n       = 1'b0;
      dif.enable  = 1'b1;
      dif.load    = 1'b0;
      dif.divisor = '0;
`ifdef FREQDIV_SYNC_EN
      dif.sync    = 1'b0;
`endif
      #12;
      check_eq("rst_cnt",     dif.count,   0);
      check_eq("rst_pulse",   dif.pulse,   0);
      check_eq("rst_square",  dif.square,  0);
      check_eq("rst_pending", dif.pending, 0);
      rst_n = 1'b1;

      // Default divisor of 10
      measure("d10", 10);

      // Load 7 at count 3; current period stays 10
      steps(3);
      check_eq("ld7_cnt3", dif.count, 3);
      dif.load = 1'b1; dif.divisor = 8'd7;
      step();
      dif.load = 1'b0;
      check_eq("ld7_pend", dif.pending, 1);
      check_eq("ld7_cnt4", dif.count, 4);
      steps(5);
      check_eq("ld7_cnt9",  dif.count,   9);
      check_eq("ld7_pend9", dif.pending, 1);
      check_eq("ld7_pulse9", dif.pulse,  0);
      step();
      check_eq("ld7_wrap_pulse", dif.pulse,   1);
      check_eq("ld7_wrap_pend",  dif.pending, 0);
      measure("d7a", 7);
      measure("d7b", 7);

      // Load 0 then 1: clamps to 2
      dif.load = 1'b1; dif.divisor = 8'd0;
      step();
      dif.divisor = 8'd1;
      step();
      dif.load = 1'b0;
      check_eq("clamp_pend", dif.pending, 1);
      check_eq("clamp_cnt2", dif.count,   2);
      steps(5);
      check_eq("clamp_wrap_pulse", dif.pulse, 1);
      check_eq("clamp_wrap_cnt",   dif.count, 0);
      measure("d2a", 2);
      measure("d2b", 2);

      // Back to 10, then freeze at count 4
      dif.load = 1'b1; dif.divisor = 8'd10;
      step();
      dif.load = 1'b0;
      step();
      check_eq("to10_pulse", dif.pulse,   1);
      check_eq("to10_pend",  dif.pending, 0);
      steps(4);
      check_eq("frz_cnt_start", dif.count, 4);
      dif.enable = 1'b0;
      frz_pulses = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (dif.pulse) frz_pulses++;
      end
      check_eq("frz_pulses", frz_pulses, 0);
      check_eq("frz_cnt",    dif.count,  4);
      check_eq("frz_square", dif.square, 1);
      dif.enable = 1'b1;
      steps(5);
      check_eq("frz_cnt9",  dif.count, 9);
      check_eq("frz_nopls", dif.pulse, 0);
      step();
      check_eq("frz_resume_pulse", dif.pulse, 1);
      check_eq("frz_resume_cnt",   dif.count, 0);

      // Load 12 then 3 before the wrap: only 3 takes effect
      steps(2);
      dif.load = 1'b1; dif.divisor = 8'd12;
      step();
      dif.divisor = 8'd3;
      step();
      dif.load = 1'b0;
      steps(5);
      check_eq("lw_cnt9", dif.count,   9);
      check_eq("lw_pend", dif.pending, 1);
      step();
      check_eq("lw_wrap_pulse", dif.pulse,   1);
      check_eq("lw_wrap_pend",  dif.pending, 0);
      measure("d3", 3);

      // Async reset mid-period discards a pending load
      step();
      dif.load = 1'b1; dif.divisor = 8'd5;
      step();
      dif.load = 1'b0;
      check_eq("pre_rst_pend", dif.pending, 1);
      check_eq("pre_rst_cnt",  dif.count,   2);
      #3 rst_n = 1'b0;
      #1;
      check_eq("arst_cnt",     dif.count,   0);
      check_eq("arst_square",  dif.square,  0);
      check_eq("arst_pulse",   dif.pulse,   0);
      check_eq("arst_pending", dif.pending, 0);
      #1 rst_n = 1'b1;
      measure("post_rst", 10);

`ifdef FREQDIV_SYNC_EN
      steps(6);
      check_eq("sync_cnt6", dif.count, 6);
      dif.sync = 1'b1;
      step();
      dif.sync = 1'b0;
      check_eq("sync_pulse",  dif.pulse,  1);
      check_eq("sync_cnt",    dif.count,  0);
      check_eq("sync_square", dif.square, 1);
      measure("sync_d10", 10);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
